// File: rtl/hazard_ctrl_pipe.sv
// hazard_ctrl_pipe: pipelines the decode-stage control bundle through the
// ID/EX, EX/MEM and MEM/WB control registers. It also detects load-use and
// ID-branch hazards, and produces the stall/flush and operand-forwarding
// selects for the EX ALU and the ID comparator.
module hazard_ctrl_pipe #(
  parameter int RFIDX_WIDTH   = 5,
  parameter int ALUCTRL_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,

  // decode-stage controls
  input  logic [ALUCTRL_WIDTH-1:0] aluctrl_d,
  input  logic [1:0]               alusrca_d,
  input  logic                     alusrcb_d,
  input  logic                     memwrite_d,
  input  logic                     lunsigned_d,
  input  logic                     memtoreg_d,
  input  logic                     regwrite_d,
  input  logic [1:0]               lwhb_d,
  input  logic [1:0]               swhb_d,
  input  logic                     pcsrc_d,
  input  logic                     cmpuse_d,
  input  logic                     use_rs1_d,
  input  logic                     use_rs2_d,
  input  logic [RFIDX_WIDTH-1:0]   rs1_d,
  input  logic [RFIDX_WIDTH-1:0]   rs2_d,
  input  logic [RFIDX_WIDTH-1:0]   rd_d,

  // EX stage
  output logic [ALUCTRL_WIDTH-1:0] aluctrl_e,
  output logic [1:0]               alusrca_e,
  output logic                     alusrcb_e,
  output logic [RFIDX_WIDTH-1:0]   rs1_e,
  output logic [RFIDX_WIDTH-1:0]   rs2_e,
  output logic [RFIDX_WIDTH-1:0]   rd_e,

  // MEM stage
  output logic                     memwrite_m,
  output logic                     lunsigned_m,
  output logic [1:0]               lwhb_m,
  output logic [1:0]               swhb_m,
  output logic [RFIDX_WIDTH-1:0]   rd_m,

  // WB stage
  output logic                     memtoreg_w,
  output logic                     regwrite_w,
  output logic [RFIDX_WIDTH-1:0]   rd_w,

  // hazard control
  output logic                     stall_f,
  output logic                     stall_d,
  output logic                     flush_d,
  output logic [1:0]               fwda_e,
  output logic [1:0]               fwdb_e,
  output logic                     fwda_d,
  output logic                     fwdb_d
);

  // EX-stage controls that are not exported but are needed downstream
  // or by the hazard logic
  logic memwrite_e;
  logic lunsigned_e;
  logic memtoreg_e;
  logic regwrite_e;
  logic [1:0] lwhb_e;
  logic [1:0] swhb_e;

  // MEM-stage controls that only feed WB and the hazard logic
  logic memtoreg_m;
  logic regwrite_m;

  // hazard terms
  logic m1_e;
  logic m2_e;
  logic m1_m;
  logic m2_m;
  logic lw_stall;
  logic br_stall;
  logic stall;

  // ID/EX register: take the decoded bundle, or insert a bubble while ID is held
  always_ff @(posedge clk) begin
    if (reset || stall) begin
      aluctrl_e   <= '0;
      alusrca_e   <= '0;
      alusrcb_e   <= 1'b0;
      memwrite_e  <= 1'b0;
      lunsigned_e <= 1'b0;
      memtoreg_e  <= 1'b0;
      regwrite_e  <= 1'b0;
      lwhb_e      <= '0;
      swhb_e      <= '0;
      rs1_e       <= '0;
      rs2_e       <= '0;
      rd_e        <= '0;
    end else begin
      aluctrl_e   <= aluctrl_d;
      alusrca_e   <= alusrca_d;
      alusrcb_e   <= alusrcb_d;
      memwrite_e  <= memwrite_d;
      lunsigned_e <= lunsigned_d;
      memtoreg_e  <= memtoreg_d;
      regwrite_e  <= regwrite_d;
      lwhb_e      <= lwhb_d;
      swhb_e      <= swhb_d;
      rs1_e       <= rs1_d;
      rs2_e       <= rs2_d;
      rd_e        <= rd_d;
    end
  end

  // EX/MEM register: advances every cycle, since stalls only hold IF and ID
  always_ff @(posedge clk) begin
    if (reset) begin
      memwrite_m  <= 1'b0;
      lunsigned_m <= 1'b0;
      lwhb_m      <= '0;
      swhb_m      <= '0;
      memtoreg_m  <= 1'b0;
      regwrite_m  <= 1'b0;
      rd_m        <= '0;
    end else begin
      memwrite_m  <= memwrite_e;
      lunsigned_m <= lunsigned_e;
      lwhb_m      <= lwhb_e;
      swhb_m      <= swhb_e;
      memtoreg_m  <= memtoreg_e;
      regwrite_m  <= regwrite_e;
      rd_m        <= rd_e;
    end
  end

  // MEM/WB register: advances every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      memtoreg_w <= 1'b0;
      regwrite_w <= 1'b0;
      rd_w       <= '0;
    end else begin
      memtoreg_w <= memtoreg_m;
      regwrite_w <= regwrite_m;
      rd_w       <= rd_m;
    end
  end

  // Detect whether the ID instruction reads a register that is still being
  // produced in EX or MEM. x0 never creates a dependency.
  always_comb begin
    m1_e = use_rs1_d && (rs1_d != '0) && (rs1_d == rd_e);
    m2_e = use_rs2_d && (rs2_d != '0) && (rs2_d == rd_e);
    m1_m = use_rs1_d && (rs1_d != '0) && (rs1_d == rd_m);
    m2_m = use_rs2_d && (rs2_d != '0) && (rs2_d == rd_m);

    lw_stall = memtoreg_e && (m1_e || m2_e);
    br_stall = cmpuse_d && ((regwrite_e && (m1_e || m2_e)) ||
                            (memtoreg_m && (m1_m || m2_m)));
    stall    = lw_stall || br_stall;
  end

  // Stall IF/ID on a hazard. A stall overrides a redirect, because the
  // comparator operands are stale and the branch is re-evaluated next cycle.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    if (!reset) begin
      stall_f = stall;
      stall_d = stall;
      flush_d = pcsrc_d && !stall;
    end
  end

  // Forwarding selects. In EX, MEM wins over WB. The ID comparator only
  // forwards ALU results from MEM; WB is covered by the write-through regfile.
  always_comb begin
    fwda_e = 2'b00;
    fwdb_e = 2'b00;
    fwda_d = 1'b0;
    fwdb_d = 1'b0;
    if (!reset) begin
      if (regwrite_m && (rd_m != '0) && (rd_m == rs1_e)) begin
        fwda_e = 2'b10;
      end else if (regwrite_w && (rd_w != '0) && (rd_w == rs1_e)) begin
        fwda_e = 2'b01;
      end

      if (regwrite_m && (rd_m != '0) && (rd_m == rs2_e)) begin
        fwdb_e = 2'b10;
      end else if (regwrite_w && (rd_w != '0) && (rd_w == rs2_e)) begin
        fwdb_e = 2'b01;
      end

      fwda_d = regwrite_m && (rd_m != '0) && (rd_m == rs1_d) && !memtoreg_m;
      fwdb_d = regwrite_m && (rd_m != '0) && (rd_m == rs2_d) && !memtoreg_m;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// tb_hazard_ctrl_pipe: randomized and directed stimulus against a
// stage-array reference model, with results checked by a scoreboard.
module tb_hazard_ctrl_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] aluctrl_d;
  logic [1:0] alusrca_d;
  logic       alusrcb_d, memwrite_d, lunsigned_d, memtoreg_d, regwrite_d;
  logic [1:0] lwhb_d, swhb_d;
  logic       pcsrc_d, cmpuse_d, use_rs1_d, use_rs2_d;
  logic [4:0] rs1_d, rs2_d, rd_d;
  logic [3:0] aluctrl_e;
  logic [1:0] alusrca_e;
  logic       alusrcb_e;
  logic [4:0] rs1_e, rs2_e, rd_e;
  logic       memwrite_m, lunsigned_m;
  logic [1:0] lwhb_m, swhb_m;
  logic [4:0] rd_m;
  logic       memtoreg_w, regwrite_w;
  logic [4:0] rd_w;
  logic       stall_f, stall_d, flush_d;
  logic [1:0] fwda_e, fwdb_e;
  logic       fwda_d, fwdb_d;

  int tests = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] aluctrl;
    logic [1:0] alusrca;
    logic       alusrcb, memwrite, lunsigned, memtoreg, regwrite;
    logic [1:0] lwhb, swhb;
    logic [4:0] rs1, rs2, rd;
  } instr_t;

  typedef struct packed {
    instr_t ins;
    logic   pcsrc, cmpuse, use1, use2;
  } id_t;

  typedef struct packed {
    logic [21:0] e;
    logic [12:0] m;
    logic [6:0]  w;
    logic [2:0]  haz;
    logic [5:0]  fwd;
  } exp_t;

  exp_t   expq[$];
  // reference pipeline: index 0 = EX, 1 = MEM, 2 = WB
  instr_t pipe[3];

  hazard_ctrl_pipe #(.RFIDX_WIDTH(5), .ALUCTRL_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .aluctrl_d(aluctrl_d), .alusrca_d(alusrca_d), .alusrcb_d(alusrcb_d),
    .memwrite_d(memwrite_d), .lunsigned_d(lunsigned_d), .memtoreg_d(memtoreg_d),
    .regwrite_d(regwrite_d), .lwhb_d(lwhb_d), .swhb_d(swhb_d),
    .pcsrc_d(pcsrc_d), .cmpuse_d(cmpuse_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .aluctrl_e(aluctrl_e), .alusrca_e(alusrca_e), .alusrcb_e(alusrcb_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .memwrite_m(memwrite_m), .lunsigned_m(lunsigned_m), .lwhb_m(lwhb_m),
    .swhb_m(swhb_m), .rd_m(rd_m),
    .memtoreg_w(memtoreg_w), .regwrite_w(regwrite_w), .rd_w(rd_w),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .fwda_e(fwda_e), .fwdb_e(fwdb_e), .fwda_d(fwda_d), .fwdb_d(fwdb_d)
  );

  always #5 clk = ~clk;

  // does the ID instruction read register r (x0 never counts)
  function automatic bit reads(id_t id, logic [4:0] r);
    return (r != 5'd0) && ((id.use1 && id.ins.rs1 == r) || (id.use2 && id.ins.rs2 == r));
  endfunction

  // where the EX operand for register r comes from
  function automatic logic [1:0] exSrc(logic [4:0] r);
    if (r != 5'd0 && pipe[1].regwrite && pipe[1].rd == r) return 2'b10;
    if (r != 5'd0 && pipe[2].regwrite && pipe[2].rd == r) return 2'b01;
    return 2'b00;
  endfunction

  // an ALU result in MEM feeds the ID comparator; a load does not
  function automatic logic idFwd(logic [4:0] r);
    return (r != 5'd0) && pipe[1].regwrite && !pipe[1].memtoreg && pipe[1].rd == r;
  endfunction

  function automatic id_t mk(bit mt, bit rw, int rs1, int rs2, int rd,
                             bit u1, bit u2, bit cmp, bit pc);
    id_t x;
    x.ins.aluctrl   = 4'($urandom_range(0, 15));
    x.ins.alusrca   = 2'($urandom_range(0, 3));
    x.ins.alusrcb   = 1'($urandom_range(0, 1));
    x.ins.memwrite  = 1'b0;
    x.ins.lunsigned = mt ? 1'($urandom_range(0, 1)) : 1'b0;
    x.ins.memtoreg  = mt;
    x.ins.regwrite  = rw;
    x.ins.lwhb      = mt ? 2'($urandom_range(0, 3)) : 2'b00;
    x.ins.swhb      = 2'b00;
    x.ins.rs1       = 5'(rs1);
    x.ins.rs2       = 5'(rs2);
    x.ins.rd        = 5'(rd);
    x.use1          = u1;
    x.use2          = u2;
    x.cmpuse        = cmp;
    x.pcsrc         = pc;
    return x;
  endfunction

  function automatic id_t randId();
    id_t x;
    x = 38'($urandom()) ^ {38'($urandom()), 6'd0};
    x.ins.rs1      = 5'($urandom_range(0, 3));
    x.ins.rs2      = 5'($urandom_range(0, 3));
    x.ins.rd       = 5'($urandom_range(0, 3));
    x.ins.memtoreg = ($urandom_range(0, 3) == 0);
    x.ins.regwrite = x.ins.memtoreg | 1'($urandom_range(0, 1));
    x.cmpuse       = ($urandom_range(0, 2) == 0);
    x.pcsrc        = ($urandom_range(0, 3) == 0);
    return x;
  endfunction

  // drive one ID cycle, predict this cycle's outputs, then advance the model
  task automatic applyStimulus(input id_t id, input bit rst, output bit stalled);
    exp_t x;
    bit   st;
    reset       = rst;
    aluctrl_d   = id.ins.aluctrl;
    alusrca_d   = id.ins.alusrca;
    alusrcb_d   = id.ins.alusrcb;
    memwrite_d  = id.ins.memwrite;
    lunsigned_d = id.ins.lunsigned;
    memtoreg_d  = id.ins.memtoreg;
    regwrite_d  = id.ins.regwrite;
    lwhb_d      = id.ins.lwhb;
    swhb_d      = id.ins.swhb;
    rs1_d       = id.ins.rs1;
    rs2_d       = id.ins.rs2;
    rd_d        = id.ins.rd;
    pcsrc_d     = id.pcsrc;
    cmpuse_d    = id.cmpuse;
    use_rs1_d   = id.use1;
    use_rs2_d   = id.use2;

    st = !rst && ((pipe[0].memtoreg && reads(id, pipe[0].rd)) ||
                  (id.cmpuse && ((pipe[0].regwrite && reads(id, pipe[0].rd)) ||
                                 (pipe[1].memtoreg && reads(id, pipe[1].rd)))));
    x.e   = {pipe[0].aluctrl, pipe[0].alusrca, pipe[0].alusrcb,
             pipe[0].rs1, pipe[0].rs2, pipe[0].rd};
    x.m   = {pipe[1].memwrite, pipe[1].lunsigned, pipe[1].lwhb, pipe[1].swhb,
             pipe[1].memtoreg, pipe[1].regwrite, pipe[1].rd};
    x.w   = {pipe[2].memtoreg, pipe[2].regwrite, pipe[2].rd};
    x.haz = {st, st, !rst && id.pcsrc && !st};
    x.fwd = rst ? 6'd0 : {exSrc(pipe[0].rs1), exSrc(pipe[0].rs2),
                          idFwd(id.ins.rs1), idFwd(id.ins.rs2)};
    expq.push_back(x);

    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 3; i++) pipe[i] = '0;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = st ? '0 : id.ins;
    end
    stalled = st;
  endtask

  // present an instruction and hold it in ID for as long as it is stalled
  task automatic issue(input id_t id);
    bit st;
    int n = 0;
    do begin
      applyStimulus(id, 1'b0, st);
      n++;
    end while (st && n < 4);
    tests++;
    if (st) begin
      failures++;
      $display("[TB] FAIL stall_bound: still stalled after %0d cycles, required at most 3", n);
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %h, required %h", name, $time, got, want);
    end
  endtask

  task automatic checkOutput(input exp_t x);
    cmp("e_bank", 32'({aluctrl_e, alusrca_e, alusrcb_e, rs1_e, rs2_e, rd_e}), 32'(x.e));
    cmp("m_bank", 32'({memwrite_m, lunsigned_m, lwhb_m, swhb_m, dut.memtoreg_m,
                       dut.regwrite_m, rd_m}), 32'(x.m));
    cmp("w_bank", 32'({memtoreg_w, regwrite_w, rd_w}), 32'(x.w));
    cmp("stall_flush", 32'({stall_f, stall_d, flush_d}), 32'(x.haz));
    cmp("forward", 32'({fwda_e, fwdb_e, fwda_d, fwdb_d}), 32'(x.fwd));
  endtask

  // monitor: compare whatever the driver predicted for this cycle
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        x = expq.pop_front();
        checkOutput(x);
      end
    end
  end

  initial begin
    bit   st;
    id_t  nop;
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) pipe[i] = '0;

    // first reset edge establishes a known state before any checking
    applyStimulusSetup();
    applyStimulus(randId(), 1'b1, st);
    applyStimulus(randId(), 1'b1, st);

    // lw x5 ; add x6,x5,x7
    issue(mk(1, 1, 1, 0, 5, 1, 0, 0, 0));
    issue(mk(0, 1, 5, 7, 6, 1, 1, 0, 0));
    repeat (3) issue(nop);

    // add x5 ; beq x5,x0 taken
    issue(mk(0, 1, 1, 2, 5, 1, 1, 0, 0));
    issue(mk(0, 0, 5, 0, 0, 1, 1, 1, 1));
    repeat (3) issue(nop);

    // lw x5 ; beq x5,x6 taken
    issue(mk(1, 1, 1, 0, 5, 1, 0, 0, 0));
    issue(mk(0, 0, 5, 6, 0, 1, 1, 1, 1));
    repeat (3) issue(nop);

    // add x5 ; sub x5 ; or x8,x5,x5 -- then the same with rd = x0
    issue(mk(0, 1, 1, 2, 5, 1, 1, 0, 0));
    issue(mk(0, 1, 3, 4, 5, 1, 1, 0, 0));
    issue(mk(0, 1, 5, 5, 8, 1, 1, 0, 0));
    repeat (3) issue(nop);
    issue(mk(0, 1, 1, 2, 0, 1, 1, 0, 0));
    issue(mk(0, 1, 3, 4, 0, 1, 1, 0, 0));
    issue(mk(0, 1, 0, 0, 8, 1, 1, 1, 0));
    repeat (3) issue(nop);

    // jal x1 with no hazard
    issue(mk(0, 1, 0, 0, 1, 0, 0, 0, 1));
    repeat (3) issue(nop);

    // reset in the middle of dependent traffic
    issue(mk(1, 1, 1, 0, 5, 1, 0, 0, 0));
    applyStimulus(mk(0, 0, 5, 6, 0, 1, 1, 1, 1), 1'b1, st);
    issue(mk(0, 0, 5, 6, 0, 1, 1, 1, 1));
    repeat (2) issue(nop);

    // randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) applyStimulus(randId(), 1'b1, st);
      else issue(randId());
    end

    tests++;
    if (expq.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  // hold reset through the first clock edge so DUT and model start from zero
  task automatic applyStimulusSetup();
    id_t x;
    x           = randId();
    reset       = 1'b1;
    aluctrl_d   = x.ins.aluctrl;
    alusrca_d   = x.ins.alusrca;
    alusrcb_d   = x.ins.alusrcb;
    memwrite_d  = x.ins.memwrite;
    lunsigned_d = x.ins.lunsigned;
    memtoreg_d  = x.ins.memtoreg;
    regwrite_d  = x.ins.regwrite;
    lwhb_d      = x.ins.lwhb;
    swhb_d      = x.ins.swhb;
    rs1_d       = x.ins.rs1;
    rs2_d       = x.ins.rs2;
    rd_d        = x.ins.rd;
    pcsrc_d     = 1'b1;
    cmpuse_d    = 1'b1;
    use_rs1_d   = 1'b1;
    use_rs2_d   = 1'b1;
    @(posedge clk);
    #1;
  endtask

endmodule
